// File: rtl/alu_ctrl.sv
// Instruction controller for the 6-bit ALU. It takes one instruction at a time
// over valid/ready, holds a 4 x DATA_W register file, and streams registers out.
module alu_ctrl #(
   parameter int DATA_W = 6,
   parameter int IMM_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        instr,
   input  logic              instrValid,
   output logic              instrReady,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   output logic              aluFun,
   input  logic [DATA_W-1:0] aluOut,
   output logic [DATA_W-1:0] dataOut,
   output logic              dataValid,
   output logic              ovf,
   output logic              busy
);

   localparam int         NREG   = 4;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_NOT = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_OUT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [7:0]        r_instr;
   logic [DATA_W-1:0] r_rf [NREG];
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic              r_alu_fun;
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_valid;
   logic              r_ovf;

   logic              w_ready;
   logic              w_accept;
   logic              w_in_decode;
   logic              w_in_exec;
   logic [1:0]        w_op;
   logic [1:0]        w_rd;
   logic [1:0]        w_rs;
   logic [DATA_W-1:0] w_rd_val;
   logic [DATA_W-1:0] w_rs_val;
   logic [DATA_W-1:0] w_imm;
   logic              w_wr_en;
   logic [DATA_W-1:0] w_wr_data;
   logic [NREG-1:0]   w_we;

   // Fields come from the latched copy, so upstream may change instr after accept.
   assign w_op     = r_instr[7:6];
   assign w_rd     = r_instr[5:4];
   assign w_rs     = r_instr[3:2];
   assign w_imm    = {{(DATA_W-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};
   assign w_rd_val = r_rf[w_rd];
   assign w_rs_val = r_rf[w_rs];

   //---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (instrValid) begin
               w_state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_op == OP_ADD || w_op == OP_NOT) begin
               w_state_next = S_EXEC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_EXEC: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_ready     = 1'b0;
      w_in_decode = 1'b0;
      w_in_exec   = 1'b0;
      case (r_state)
         S_IDLE:   w_ready     = 1'b1;
         S_DECODE: w_in_decode = 1'b1;
         S_EXEC:   w_in_exec   = 1'b1;
         default:  w_ready     = 1'b0;
      endcase
   end

   assign w_accept = w_ready && instrValid;

   //---------------------------------------------------------- register file
   // LDI writes during DECODE, ALU results during EXEC; never both in a cycle.
   assign w_wr_en   = w_in_exec || (w_in_decode && w_op == OP_LDI);
   assign w_wr_data = w_in_exec ? aluOut : w_imm;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_we
         assign w_we[gi] = w_wr_en && (w_rd == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (!rst_n) begin
            r_rf[i] <= '0;
         end else if (w_we[i]) begin
            r_rf[i] <= w_wr_data;
         end
      end
   end

   //---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr      <= '0;
         r_op1        <= '0;
         r_op2        <= '0;
         r_alu_fun    <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         if (w_accept) begin
            r_instr <= instr;
         end
         if (w_in_decode) begin
            case (w_op)
               OP_ADD: begin
                  r_op1     <= w_rd_val;
                  r_op2     <= w_rs_val;
                  r_alu_fun <= 1'b0;
               end
               OP_NOT: begin
                  r_op1     <= w_rd_val;
                  r_op2     <= '0;
                  r_alu_fun <= 1'b1;
               end
               OP_OUT: begin
                  r_data_out   <= w_rd_val;
                  r_data_valid <= 1'b1;
               end
               default: begin
               end
            endcase
         end
         // Signed overflow: like-signed operands giving a differently signed sum.
         if (w_in_exec && w_op == OP_ADD) begin
            r_ovf <= (r_op1[DATA_W-1] == r_op2[DATA_W-1]) &&
                     (aluOut[DATA_W-1] != r_op1[DATA_W-1]);
         end
      end
   end

   assign instrReady = w_ready;
   assign busy       = ~w_ready;
   assign op1        = r_op1;
   assign op2        = r_op2;
   assign aluFun     = r_alu_fun;
   assign dataOut    = r_data_out;
   assign dataValid  = r_data_valid;
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural ALU closing the loop on
// op1/op2/aluFun -> aluOut. Expected values are hand-computed constants.
module tb_alu_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] instr;
   logic       instrValid;
   logic       instrReady;
   logic [5:0] op1;
   logic [5:0] op2;
   logic       aluFun;
   logic [5:0] aluOut;
   logic [5:0] dataOut;
   logic       dataValid;
   logic       ovf;
   logic       busy;

   int npass  = 0;
   int ntotal = 0;

   alu_ctrl #(.DATA_W(6), .IMM_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .instrValid (instrValid),
      .instrReady (instrReady),
      .op1        (op1),
      .op2        (op2),
      .aluFun     (aluFun),
      .aluOut     (aluOut),
      .dataOut    (dataOut),
      .dataValid  (dataValid),
      .ovf        (ovf),
      .busy       (busy)
   );

   assign aluOut = aluFun ? ~op1 : (op1 + op2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      ntotal++;
      assert (obs === exp_v) npass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
   endtask

   // Returns at a falling edge with instrReady high, or reports a timeout.
   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!instrReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instrReady) chk({tag, "_idle_timeout"}, 8'(instrReady), 8'd1);
   endtask

   task automatic send(input logic [7:0] ins);
      wait_idle("send");
      instr      = ins;
      instrValid = 1'b1;
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      $display("instr 0x%02h accepted at %0t", ins, $time);
   endtask

   task automatic do_out(input logic [7:0] ins, input logic [5:0] exp_v, input string tag);
      send(ins);
      @(negedge clk);
      chk({tag, "_dv_decode"}, 8'(dataValid), 8'd0);
      @(negedge clk);
      chk({tag, "_dv_pulse"}, 8'(dataValid), 8'd1);
      chk({tag, "_dataOut"}, 8'(dataOut), 8'(exp_v));
      @(negedge clk);
      chk({tag, "_dv_end"}, 8'(dataValid), 8'd0);
      $display("OUT 0x%02h -> dataOut=0x%02h", ins, dataOut);
   endtask

   initial begin
      int nready;
      int dv_seen;
      rst_n      = 1'b0;
      instr      = 8'h00;
      instrValid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_ready", 8'(instrReady), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_op1", 8'(op1), 8'd0);
      chk("rst_op2", 8'(op2), 8'd0);
      chk("rst_aluFun", 8'(aluFun), 8'd0);
      chk("rst_dataOut", 8'(dataOut), 8'd0);
      chk("rst_dataValid", 8'(dataValid), 8'd0);
      chk("rst_ovf", 8'(ovf), 8'd0);

      // LDI r0,5; LDI r1,-3; ADD r0,r1; OUT r0 -> 2
      send(8'h85);
      send(8'h9D);
      send(8'h04);
      wait_idle("add1");
      chk("add1_ovf", 8'(ovf), 8'd0);
      do_out(8'hC0, 6'd2, "out_r0");

      // NOT r1 -> ~111101 = 000010
      send(8'h50);
      @(negedge clk);
      @(negedge clk);
      chk("not_exec_op1", 8'(op1), 8'h3D);
      chk("not_exec_op2", 8'(op2), 8'h00);
      chk("not_exec_aluFun", 8'(aluFun), 8'd1);
      do_out(8'hD0, 6'b000010, "out_r1");

      // Doubling r2 = 7 -> 14 -> 28 -> 56 (wraps to -8, overflow)
      send(8'hA7);
      send(8'h28);
      wait_idle("dbl1");
      chk("dbl1_ovf", 8'(ovf), 8'd0);
      do_out(8'hE0, 6'd14, "dbl1_r2");
      send(8'h28);
      wait_idle("dbl2");
      chk("dbl2_ovf", 8'(ovf), 8'd0);
      do_out(8'hE0, 6'd28, "dbl2_r2");
      send(8'h28);
      wait_idle("dbl3");
      chk("dbl3_ovf", 8'(ovf), 8'd1);
      do_out(8'hE0, 6'b111000, "dbl3_r2");
      chk("dbl3_ovf_held", 8'(ovf), 8'd1);

      // Reset during EXEC of ADD r0,r1 with r0=5, r1=3
      send(8'h85);
      send(8'h93);
      send(8'h04);
      @(negedge clk);
      @(negedge clk);
      chk("abort_op1", 8'(op1), 8'd5);
      chk("abort_op2", 8'(op2), 8'd3);
      chk("abort_aluOut", 8'(aluOut), 8'd8);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 8'(instrReady), 8'd1);
      chk("abort_ovf", 8'(ovf), 8'd0);
      chk("abort_dataOut", 8'(dataOut), 8'd0);

      // Idle for 10 cycles: nothing moves
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         chk("idle_ready", 8'(instrReady), 8'd1);
         chk("idle_busy", 8'(busy), 8'd0);
         chk("idle_op1", 8'(op1), 8'd0);
         chk("idle_op2", 8'(op2), 8'd0);
         chk("idle_dataOut", 8'(dataOut), 8'd0);
      end
      do_out(8'hC0, 6'd0, "abort_r0");
      do_out(8'hD0, 6'd0, "abort_r1");

      // Back-to-back ADD r3,r0 with r0=2, valid held high for 27 cycles
      send(8'h82);
      wait_idle("stream");
      instr      = 8'h30;
      instrValid = 1'b1;
      nready     = 0;
      dv_seen    = 0;
      for (int i = 0; i < 27; i++) begin
         if (i > 0) @(negedge clk);
         if (instrReady) nready++;
         if (dataValid) dv_seen++;
         chk("stream_busy", 8'(busy), 8'(!instrReady));
      end
      instrValid = 1'b0;
      $display("stream: %0d accepts in 27 cycles", nready);
      chk("stream_accepts", 8'(nready), 8'd9);
      chk("stream_dv", 8'(dv_seen), 8'd0);
      wait_idle("stream_end");
      chk("stream_ovf", 8'(ovf), 8'd0);
      do_out(8'hF0, 6'd18, "stream_r3");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
